// File: rtl/regfile_scoreboard.sv
// Parametrised register file with init sweep, ready flag, per-register busy scoreboard and debug tap.
// Optional same-cycle write-to-read bypass is compiled in with RF_WRITE_BYPASS_EN.

module regfile_scoreboard_entry #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_we,
    input  logic [DATA_W-1:0] init_val,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wd,
    input  logic              set,
    input  logic              clr,
    output logic [DATA_W-1:0] data,
    output logic              busy
);

    // Storage is not reset; the init sweep gives every entry a defined value.
    always_ff @(posedge clk) begin
        if (init_we)
            data <= init_val;
        else if (wr_en)
            data <= wd;
    end

    // A new producer supersedes the writeback landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst)
            busy <= 1'b0;
        else if (set)
            busy <= 1'b1;
        else if (clr)
            busy <= 1'b0;
    end

endmodule

module regfile_scoreboard #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int INIT_MODE = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic [ADDR_W-1:0] dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] LAST  = (ADDR_W+1)'(DEPTH - 1);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                       state_q, state_d;
    logic [ADDR_W:0]              cnt_q, cnt_d;
    logic                         run;
    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST)
                state_d = S_RUN;
        end
    end

    assign run = (state_q == S_RUN);

    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
        if (i == 0) begin : g_zero
            assign mem[i]  = '0;
            assign busy[i] = 1'b0;
        end else begin : g_entry
            localparam logic [DATA_W-1:0] INIT_VAL = (INIT_MODE != 0) ? DATA_W'(i) : '0;
            logic init_we, wr_en, set;

            assign init_we = !rst && !run && (cnt_q[ADDR_W-1:0] == ADDR_W'(i));
            assign wr_en   = !rst && run && we && (wa == ADDR_W'(i));
            assign set     = run && issue_en && (issue_addr == ADDR_W'(i));

            regfile_scoreboard_entry #(.DATA_W(DATA_W)) u_entry (
                .clk      (clk),
                .rst      (rst),
                .init_we  (init_we),
                .init_val (INIT_VAL),
                .wr_en    (wr_en),
                .wd       (wd),
                .set      (set),
                .clr      (wr_en),
                .data     (mem[i]),
                .busy     (busy[i])
            );
        end
    end

    assign ready = run;

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        dbg_data = '0;
        if (run) begin
            rs1_data = mem[rs1_addr];
            rs2_data = mem[rs2_addr];
            rs1_busy = busy[rs1_addr];
            rs2_busy = busy[rs2_addr];
            dbg_data = mem[dbg_sel];
`ifdef RF_WRITE_BYPASS_EN
            // Forward the in-flight write; dbg_data stays a pure storage tap.
            if (we && (wa != '0) && (wa == rs1_addr)) begin
                rs1_data = wd;
                rs1_busy = issue_en && (issue_addr == wa);
            end
            if (we && (wa != '0) && (wa == rs2_addr)) begin
                rs2_data = wd;
                rs2_busy = issue_en && (issue_addr == wa);
            end
`endif
        end
    end

endmodule
